// File: rtl/mpu_csr_master.sv
// CSR initiator that launches an MPU run, services its interrupts, forwards 64-bit user data
// to a consumer, and reports end/error/abort/timeout back to the command side.
module mpu_csr_master #(
  parameter logic [3:0]  csr_addr = 4'h0,
  parameter logic [9:0]  reg_stat = 10'h000,
  parameter logic [9:0]  reg_ctrl = 10'h001,
  parameter logic [9:0]  reg_udl  = 10'h002,
  parameter logic [9:0]  reg_udh  = 10'h003,
  parameter logic [31:0] timeout  = 32'd1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_di,
  input  logic [31:0] csr_do,
  input  logic        irq,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [63:0] ud_data,
  output logic        ud_valid,
  input  logic        ud_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR0, S_GO, S_GUARD, S_WAIT_IRQ, S_RD_STAT, S_RD_L,
    S_RD_H, S_HAND, S_ACK, S_STOP, S_CLR1, S_FIN
  } state_t;

  localparam logic [1:0] RES_END   = 2'b00;
  localparam logic [1:0] RES_ERR   = 2'b01;
  localparam logic [1:0] RES_ABORT = 2'b10;
  localparam logic [1:0] RES_TMO   = 2'b11;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  result_q, result_d;
  logic [13:0] csr_a_q, csr_a_d;
  logic        csr_we_q, csr_we_d;
  logic [31:0] csr_di_q, csr_di_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  status_q, status_d;
  logic [63:0] ud_data_q, ud_data_d;
  logic        ud_valid_q, ud_valid_d;
  logic        abortable;

  always_comb begin
    state_d   = state_q;
    phase_d   = 1'b0;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ud_data_d = ud_data_q;
    abortable = !(state_q inside {S_IDLE, S_STOP, S_CLR1, S_FIN});

    case (state_q)
      S_IDLE:  if (cmd_start) state_d = S_CLR0;
      S_CLR0:  state_d = S_GO;
      S_GO:    state_d = S_GUARD;
      S_GUARD: begin
        if (phase_q) begin
          state_d = S_WAIT_IRQ;
          cnt_d   = 32'd0;
        end else begin
          phase_d = 1'b1;
        end
      end
      S_WAIT_IRQ: begin
        cnt_d = cnt_q + 32'd1;
        if (irq) begin
          state_d = S_RD_STAT;
        end else if ((timeout != 32'd0) && (cnt_q == timeout - 32'd1)) begin
          result_d = RES_TMO;
          state_d  = S_STOP;
        end
      end
      S_RD_STAT: begin
        // Read data is valid on the second cycle of every read state.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (csr_do[1]) begin
          result_d = RES_ERR;
          state_d  = S_CLR1;
        end else if (csr_do[0]) begin
          result_d = RES_END;
          state_d  = S_CLR1;
        end else if (csr_do[2]) begin
          state_d = S_RD_L;
        end else begin
          state_d = S_WAIT_IRQ;
        end
      end
      S_RD_L: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          ud_data_d[31:0] = csr_do;
          state_d         = S_RD_H;
        end
      end
      S_RD_H: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          ud_data_d[63:32] = csr_do;
          state_d          = S_HAND;
        end
      end
      S_HAND:  if (ud_valid_q && ud_ready) state_d = S_ACK;
      S_ACK:   state_d = S_GUARD;
      S_STOP:  state_d = S_CLR1;
      S_CLR1:  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A write in flight completes this cycle anyway; a pending read is simply abandoned.
    if (cmd_stop && abortable) begin
      result_d  = RES_ABORT;
      state_d   = S_STOP;
      phase_d   = 1'b0;
      cnt_d     = cnt_q;
      ud_data_d = ud_data_q;
    end

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    status_d   = done_d ? result_d : status_q;
    ud_valid_d = (state_d == S_HAND);

    // Bus outputs are registered, so they are decoded from the state being entered.
    csr_we_d = 1'b0;
    csr_a_d  = 14'd0;
    csr_di_d = 32'd0;
    case (state_d)
      S_CLR0, S_CLR1: begin
        csr_we_d = 1'b1;
        csr_a_d  = {csr_addr, reg_stat};
        csr_di_d = 32'h7;
      end
      S_GO: begin
        csr_we_d = 1'b1;
        csr_a_d  = {csr_addr, reg_ctrl};
        csr_di_d = 32'h3;
      end
      S_ACK: begin
        csr_we_d = 1'b1;
        csr_a_d  = {csr_addr, reg_stat};
        csr_di_d = 32'h4;
      end
      S_STOP: begin
        csr_we_d = 1'b1;
        csr_a_d  = {csr_addr, reg_ctrl};
        csr_di_d = 32'h1;
      end
      S_RD_STAT: csr_a_d = {csr_addr, reg_stat};
      S_RD_L:    csr_a_d = {csr_addr, reg_udl};
      S_RD_H:    csr_a_d = {csr_addr, reg_udh};
      default:   csr_a_d = 14'd0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= 32'd0;
      result_q   <= 2'b00;
      csr_a_q    <= 14'd0;
      csr_we_q   <= 1'b0;
      csr_di_q   <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 2'b00;
      ud_data_q  <= 64'd0;
      ud_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      csr_a_q    <= csr_a_d;
      csr_we_q   <= csr_we_d;
      csr_di_q   <= csr_di_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      status_q   <= status_d;
      ud_data_q  <= ud_data_d;
      ud_valid_q <= ud_valid_d;
    end
  end

  assign csr_a    = csr_a_q;
  assign csr_we   = csr_we_q;
  assign csr_di   = csr_di_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign status   = status_q;
  assign ud_data  = ud_data_q;
  assign ud_valid = ud_valid_q;

endmodule

// File: tb/tb_mpu_csr_master.sv
// Directed bench for mpu_csr_master with a small W1C target model and a CSR access log.
module tb_mpu_csr_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic        cmd_start, cmd_stop;
  logic        busy, done;
  logic [1:0]  status;
  logic [63:0] ud_data;
  logic        ud_valid, ud_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  mpu_csr_master #(.csr_addr(4'h5), .timeout(32'd16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .irq(irq), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .busy(busy), .done(done), .status(status),
    .ud_data(ud_data), .ud_valid(ud_valid), .ud_ready(ud_ready)
  );

  localparam logic [13:0] A_STAT = {4'h5, 10'h000};
  localparam logic [13:0] A_CTRL = {4'h5, 10'h001};
  localparam logic [13:0] A_UDL  = {4'h5, 10'h002};
  localparam logic [13:0] A_UDH  = {4'h5, 10'h003};

  // Target: STAT is write-one-to-clear, irq is the OR of STAT, reads return one cycle later.
  logic [2:0]  stat_r;
  logic [2:0]  raise;
  logic [31:0] udl_v, udh_v;
  logic [2:0]  stat_clr;
  assign stat_clr = (csr_we && csr_a == A_STAT) ? csr_di[2:0] : 3'b000;
  assign irq = |stat_r;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      stat_r <= 3'b000;
      csr_do <= 32'd0;
    end else begin
      stat_r <= (stat_r & ~stat_clr) | raise;
      if (csr_a == A_STAT)     csr_do <= {29'd0, stat_r};
      else if (csr_a == A_UDL) csr_do <= udl_v;
      else if (csr_a == A_UDH) csr_do <= udh_v;
      else                     csr_do <= 32'd0;
    end
  end

  // Access log: one entry per write cycle and per distinct read access.
  int          cyc = 0;
  logic [47:0] ev_q[$];
  int          ev_t[$];
  logic [13:0] prev_a  = 14'd0;
  logic        prev_we = 1'b0;

  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (csr_we || (csr_a != 14'd0 && (csr_a != prev_a || prev_we))) begin
      ev_q.push_back({csr_we, 1'b0, csr_a, csr_di});
      ev_t.push_back(cyc);
    end
    prev_a  = csr_a;
    prev_we = csr_we;
  end

  function automatic logic [47:0] ev(input logic we, input logic [13:0] a, input logic [31:0] d);
    return {we, 1'b0, a, d};
  endfunction

  function automatic logic [47:0] get_ev(input int idx);
    if (idx < ev_q.size()) return ev_q[idx];
    return '1;
  endfunction

  function automatic int get_t(input int idx);
    if (idx < ev_t.size()) return ev_t[idx];
    return -1;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  int base;

  task automatic start_run;
    base      = ev_q.size();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    repeat (5) tick();
  endtask

  task automatic pulse_raise(input logic [2:0] bits);
    raise = bits;
    tick();
    raise = 3'b000;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_status);
    for (int i = 0; i < 200 && !done; i++) tick();
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_status"}, status, exp_status);
    tick();
    check({tag, "_busy_low_after"}, busy, 1'b0);
    check({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100 && !ud_valid; i++) tick();
    check({tag, "_ud_valid_seen"}, ud_valid, 1'b1);
  endtask

  task automatic check_normal_log(input string tag);
    check({tag, "_ev_count"}, ev_q.size() - base, 4);
    check({tag, "_ev0"}, get_ev(base + 0), ev(1'b1, A_STAT, 32'h7));
    check({tag, "_ev1"}, get_ev(base + 1), ev(1'b1, A_CTRL, 32'h3));
    check({tag, "_ev2"}, get_ev(base + 2), ev(1'b0, A_STAT, 32'h0));
    check({tag, "_ev3"}, get_ev(base + 3), ev(1'b1, A_STAT, 32'h7));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sys_rst_n = 1'b0;
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    ud_ready  = 1'b0;
    raise     = 3'b000;
    udl_v     = 32'hDEADBEEF;
    udh_v     = 32'h01234567;
    repeat (3) tick();
    check("reset_outputs", {csr_a, csr_we, csr_di, busy, done, status, ud_valid, ud_data}, '0);
    sys_rst_n = 1'b1;
    repeat (2) tick();

    // Normal end
    start_run();
    pulse_raise(3'b001);
    wait_done("normal", 2'b00);
    check_normal_log("normal");

    // User data, held consumer, then end on a second irq
    start_run();
    pulse_raise(3'b100);
    wait_valid("ud");
    check("ud_data", ud_data, 64'h01234567DEADBEEF);
    repeat (5) tick();
    check("ud_valid_held", ud_valid, 1'b1);
    check("ud_data_stable", ud_data, 64'h01234567DEADBEEF);
    ud_ready = 1'b1;
    raise    = 3'b001;
    tick();
    ud_ready = 1'b0;
    raise    = 3'b000;
    check("ud_valid_cleared", ud_valid, 1'b0);
    wait_done("ud", 2'b00);
    check("ud_ev_count", ev_q.size() - base, 8);
    check("ud_ev2", get_ev(base + 2), ev(1'b0, A_STAT, 32'h0));
    check("ud_ev3", get_ev(base + 3), ev(1'b0, A_UDL, 32'h0));
    check("ud_ev4", get_ev(base + 4), ev(1'b0, A_UDH, 32'h0));
    check("ud_ev5_ack", get_ev(base + 5), ev(1'b1, A_STAT, 32'h4));
    check("ud_ev6", get_ev(base + 6), ev(1'b0, A_STAT, 32'h0));
    check("ud_ev7", get_ev(base + 7), ev(1'b1, A_STAT, 32'h7));
    check("ud_guard_gap", get_t(base + 6) - get_t(base + 5), 4);

    // Error bit wins over end and user bits
    start_run();
    pulse_raise(3'b111);
    wait_done("err", 2'b01);
    check_normal_log("err");

    // Timeout with no irq
    start_run();
    wait_done("tmo", 2'b11);
    check("tmo_ev_count", ev_q.size() - base, 4);
    check("tmo_ev1", get_ev(base + 1), ev(1'b1, A_CTRL, 32'h3));
    check("tmo_ev2", get_ev(base + 2), ev(1'b1, A_CTRL, 32'h1));
    check("tmo_ev3", get_ev(base + 3), ev(1'b1, A_STAT, 32'h7));
    check("tmo_wait_cycles", get_t(base + 2) - get_t(base + 1), 19);

    // Abort while user data is offered
    start_run();
    pulse_raise(3'b100);
    wait_valid("abort");
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    check("abort_ud_valid_drop", ud_valid, 1'b0);
    wait_done("abort", 2'b10);
    check("abort_ev_count", ev_q.size() - base, 7);
    check("abort_ev5", get_ev(base + 5), ev(1'b1, A_CTRL, 32'h1));
    check("abort_ev6", get_ev(base + 6), ev(1'b1, A_STAT, 32'h7));

    // Asynchronous reset during the STAT read, then a clean run
    start_run();
    pulse_raise(3'b001);
    for (int i = 0; i < 50 && !(csr_a == A_STAT && !csr_we); i++) tick();
    check("rst_reached_rd_stat", csr_a, A_STAT);
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {csr_a, csr_we, csr_di, busy, done, status, ud_valid, ud_data}, '0);
    tick();
    sys_rst_n = 1'b1;
    repeat (2) tick();
    start_run();
    pulse_raise(3'b001);
    wait_done("post_rst", 2'b00);
    check_normal_log("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu_csr_master.md
Name: mpu_csr_master

Overview:
- Hardware CSR initiator that drives the MPU control interface's CSR slave port, so a fabric block can run MPU programs without CPU involvement.
- Control flow: clears stale events, launches the MPU, and waits for irq. It then decodes STAT, fetches 64-bit user data on user IRQs, hands that data to a consumer, and acknowledges so the MPU resumes.
- It reports end, error, abort and timeout to the command side.
- Sits between a local controller (command/result/user-data ports) and the CSR bus of one MPU control interface.

Parameters:
- csr_addr, 4'h0: CSR bank of the target; driven on csr_a[13:10] for every access.
- reg_stat, 10'h000: STAT offset. Bit0 = end, bit1 = error, bit2 = user_irq; write-one-to-clear.
- reg_ctrl, 10'h001: CTRL offset. Bit0 = irq_en, bit1 = start.
- reg_udl, 10'h002: user data [31:0] offset.
- reg_udh, 10'h003: user data [63:32] offset.
- timeout, 32'd1000000: maximum sys_clk cycles spent in WAIT_IRQ before abort. 0 disables the timeout.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- csr_a  out  14  CSR address (registered).
- csr_we  out  1  CSR write strobe (registered).
- csr_di  out  32  CSR write data (registered).
- csr_do  in  32  CSR read data from the target.
- irq  in  1  level interrupt from the target.
- cmd_start  in  1  one-cycle pulse; launch the MPU.
- cmd_stop  in  1  one-cycle pulse; abort the run.
- busy  out  1  high from an accepted cmd_start until done.
- done  out  1  one-cycle pulse at end of run.
- status  out  2  valid with done: 00 end, 01 error, 10 aborted, 11 timeout.
- ud_data  out  64  user data from the MPU.
- ud_valid  out  1  ud_data valid; held until ud_ready.
- ud_ready  in  1  consumer accept.

Behaviour:
- Reset: csr_a, csr_we, csr_di = 0; busy, done, ud_valid = 0; status = 00; ud_data = 0; timeout counter = 0; state IDLE.
- CSR bus timing:
  - One access per state.
  - Write: csr_a, csr_we = 1 and csr_di are driven for exactly one cycle.
  - Read: csr_a is driven with csr_we = 0 on edge k; csr_do is captured on edge k+2 (2-cycle read states).
  - When no access is in progress: csr_we = 0, csr_a = 0, csr_di = 0.
- States:
  - IDLE: on cmd_start, set busy = 1 and go to CLR0. cmd_stop is ignored.
  - CLR0: write STAT = 32'h7. Go to GO.
  - GO: write CTRL = 32'h3. Go to GUARD.
  - GUARD: 2 idle cycles, letting irq settle after a write. Then go to WAIT_IRQ and zero the timeout counter.
  - WAIT_IRQ: count up each cycle.
    - On irq = 1: go to RD_STAT.
    - When the count reaches timeout - 1 (timeout != 0): latch result 11 and go to STOP.
  - RD_STAT: 2 cycles; capture stat = csr_do[2:0]. Decode priority:
    - bit1 set: result 01, go to CLR1.
    - else bit0 set: result 00, go to CLR1.
    - else bit2 set: go to RD_L.
    - else (spurious): go to WAIT_IRQ; the counter is not reset.
  - RD_L: 2 cycles; ud_data[31:0] <= csr_do. Go to RD_H.
  - RD_H: 2 cycles; ud_data[63:32] <= csr_do; set ud_valid = 1. Go to HAND.
  - HAND: hold ud_data and ud_valid until ud_valid & ud_ready. Then clear ud_valid and go to ACK.
  - ACK: write STAT = 32'h4 so the MPU resumes. Go to GUARD.
  - STOP: write CTRL = 32'h1 (start = 0, irq_en kept). Go to CLR1.
  - CLR1: write STAT = 32'h7. Go to FIN.
  - FIN: pulse done for one cycle with status = result; busy = 0. Go to IDLE.
- cmd_stop while busy, in any state except STOP/CLR1/FIN:
  - Latch result 10.
  - If the current CSR access is in flight (second read cycle or a write cycle), finish it, then go to STOP.
  - If in HAND: drop ud_valid immediately and discard the data.
  - cmd_stop takes priority over irq and over timeout in the same cycle.
- cmd_start while busy: ignored.
- Simultaneous cmd_start and cmd_stop in IDLE: start wins.
- Reset mid-run: the block returns to IDLE immediately. No stop write is issued; the target has its own reset.
- ud_valid is never asserted outside HAND. ud_data changes only in RD_L/RD_H.

Test Plan:
- Normal end: cmd_start, then target raises irq with STAT = 3'b001.
  - CSR writes in order: STAT 0x7, CTRL 0x3, then read STAT, then STAT 0x7.
  - done pulses with status 00; busy low the following cycle.
- User data: target returns STAT = 3'b100, UDL = 0xDEADBEEF, UDH = 0x01234567; ud_ready is held low for 5 cycles.
  - ud_data = 64'h01234567DEADBEEF is stable while ud_valid is high.
  - After ud_ready: write STAT 0x4, wait 2 guard cycles, then return to WAIT_IRQ.
  - Second irq with STAT = 0x1 gives status 00.
- Error wins: STAT = 3'b111 on the first read → status 01, and no UDL/UDH reads are issued.
- Timeout: timeout = 16, irq never asserted.
  - Exactly 16 cycles in WAIT_IRQ, then writes CTRL 0x1 and STAT 0x7.
  - done with status 11.
- Abort in HAND: cmd_stop while ud_valid = 1.
  - ud_valid drops the next cycle; CTRL 0x1 and STAT 0x7 are written.
  - status 10; no STAT 0x4 write occurs.
- Async reset: assert sys_rst_n = 0 during RD_STAT.
  - All outputs are 0 before the next sys_clk edge.
  - After release, a new cmd_start runs a full sequence correctly.
